// File: rtl/tt_rebot449_lingret_alu_seq_if.sv
// Byte-stream, ALU-drive and result-port signals of the lingret ALU sequencer.
// The master modport is the sequencer side; slave is the surrounding bus/ALU.
interface tt_rebot449_lingret_alu_seq_if;
  logic [7:0] i_byte;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_alu_instr;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [7:0] i_alu_result;
  logic [7:0] o_result;
  logic       o_result_valid;
  logic       i_result_ack;
  logic       o_busy;

  modport master (
    input  i_byte, i_valid, i_alu_result, i_result_ack,
    output o_ready, o_alu_instr, o_alu_a, o_alu_b, o_result, o_result_valid, o_busy
  );

  modport slave (
    output i_byte, i_valid, i_alu_result, i_result_ack,
    input  o_ready, o_alu_instr, o_alu_a, o_alu_b, o_result, o_result_valid, o_busy
  );
endinterface

// File: rtl/tt_rebot449_lingret_alu_seq.sv
// Lingret ALU issuing sequencer: collects opcode/A/B bytes, drives the ALU,
// waits EXEC_CYCLES, then captures the result into the accumulator.
module tt_rebot449_lingret_alu_seq #(
  parameter int EXEC_CYCLES = 1,
  parameter bit HOLD_RESULT = 1'b1
) (
  input logic i_clk,
  input logic i_rst,
  tt_rebot449_lingret_alu_seq_if.master bus
);

  typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] instr_reg, instr_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] result_reg, result_next;
  logic       valid_reg, valid_next;
  logic       busy_reg, busy_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       ready;
  logic       xfer;

  assign ready = (state_reg == S_OP) || (state_reg == S_A) || (state_reg == S_B);
  assign xfer  = ready && bus.i_valid;

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    valid_next  = valid_reg;
    busy_next   = busy_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_OP: begin
        if (xfer) begin
          instr_next = bus.i_byte;
          busy_next  = 1'b1;
          // CHAIN bit: the accumulator becomes operand A and S_A is skipped
          if (bus.i_byte[3]) begin
            a_next     = result_reg;
            state_next = S_B;
          end else begin
            state_next = S_A;
          end
        end
      end
      S_A: begin
        if (xfer) begin
          a_next     = bus.i_byte;
          state_next = S_B;
        end
      end
      S_B: begin
        if (xfer) begin
          b_next     = bus.i_byte;
          cnt_next   = 4'(EXEC_CYCLES - 1);
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_reg == 4'd0) begin
          result_next = bus.i_alu_result;
          valid_next  = 1'b1;
          state_next  = S_DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_DONE: begin
        if (!HOLD_RESULT || bus.i_result_ack) begin
          valid_next = 1'b0;
          busy_next  = 1'b0;
          state_next = S_OP;
        end
      end
      default: state_next = S_OP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= S_OP;
      instr_reg  <= 8'h00;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      result_reg <= 8'h00;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      cnt_reg    <= 4'd0;
    end else begin
      state_reg  <= state_next;
      instr_reg  <= instr_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_alu_instr    = instr_reg;
  assign bus.o_alu_a        = a_reg;
  assign bus.o_alu_b        = b_reg;
  assign bus.o_result       = result_reg;
  assign bus.o_result_valid = valid_reg;
  assign bus.o_busy         = busy_reg;

endmodule
